// File: rtl/sr_pkg.sv
// sr_pkg: shared types and default parameters for the sr_ff command generator.
package sr_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, VERIFY} state_t;
    typedef enum logic {CMD_SET, CMD_CLR} cmd_t;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_DB_CYCLES    = 4;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_CNT_W        = 8;
endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: synchroniser, stable-count debounce filter and rising-edge pulse for one raw line.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   level;
    logic                   synced;
    logic                   qualify;

    assign synced  = sync[SYNC_STAGES-1];
    assign qualify = (synced != level) && (cnt == CNT_W'(DB_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], din};
            cnt   <= (synced == level || qualify) ? '0 : cnt + 1'b1;
            level <= qualify ? synced : level;
            rise  <= qualify && synced;
        end
    end
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounces raw set/clear requests and drives exclusive, verified s/r pulses into sr_ff.
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic collision,
    output logic err
);
    logic set_req, clr_req, set_arb, set_any, clr_any;
    state_t state, state_nxt;
    cmd_t cmd, cmd_nxt;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic set_pend, clr_pend, set_pend_nxt, clr_pend_nxt, collision_nxt, err_nxt;

    sr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W))
        u_db_set (.clk(clk), .rst(rst), .din(set_in), .rise(set_req));
    sr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W))
        u_db_clr (.clk(clk), .rst(rst), .din(clr_in), .rise(clr_req));

    // Clear always wins a same-cycle race, so set is discarded before it can be queued.
    assign set_arb = set_req && !clr_req;
    assign set_any = set_arb || set_pend;
    assign clr_any = clr_req || clr_pend;

    assign s    = (state == DRIVE) && (cmd == CMD_SET);
    assign r    = (state == DRIVE) && (cmd == CMD_CLR);
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd;
        pcnt_nxt      = pcnt;
        set_pend_nxt  = set_pend || set_arb;
        clr_pend_nxt  = clr_pend || clr_req;
        collision_nxt = set_req && clr_req;
        err_nxt       = err;
        case (state)
            IDLE: begin
                set_pend_nxt  = 1'b0;
                clr_pend_nxt  = 1'b0;
                collision_nxt = collision_nxt || (set_any && clr_any);
                pcnt_nxt      = '0;
                state_nxt     = (set_any || clr_any) ? DRIVE : IDLE;
                cmd_nxt       = clr_any ? CMD_CLR : (set_any ? CMD_SET : cmd);
            end
            DRIVE: begin
                state_nxt = (pcnt == CNT_W'(PULSE_CYCLES - 1)) ? VERIFY : DRIVE;
                pcnt_nxt  = (pcnt == CNT_W'(PULSE_CYCLES - 1)) ? '0 : pcnt + 1'b1;
            end
            VERIFY: begin
                err_nxt   = err || (q_fb != (cmd == CMD_SET));
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd       <= CMD_SET;
            pcnt      <= '0;
            set_pend  <= 1'b0;
            clr_pend  <= 1'b0;
            collision <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd       <= cmd_nxt;
            pcnt      <= pcnt_nxt;
            set_pend  <= set_pend_nxt;
            clr_pend  <= clr_pend_nxt;
            collision <= collision_nxt;
            err       <= err_nxt;
        end
    end
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: scoreboard bench; expected per-edge {s,r,busy,collision,err} traces are queued then popped.
module tb_sr_cmd_gen;
    localparam int SB = 4, RB = 3, BB = 2, CB = 1;
    logic clk = 1'b0, rst = 1'b0, set_in = 1'b0, clr_in = 1'b0, q_fb;
    logic s, r, busy, collision, err;
    logic q_model, tie0 = 1'b0;
    logic [4:0] sb[$];
    logic [4:0] exp_v;
    int n_chk = 0, n_fail = 0;

    sr_cmd_gen dut (.clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .q_fb(q_fb),
                    .s(s), .r(r), .busy(busy), .collision(collision), .err(err));

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) q_model <= 1'b0;
        else if (s) q_model <= 1'b1;
        else if (r) q_model <= 1'b0;
    assign q_fb = tie0 ? 1'b0 : q_model;

    function automatic void fill(int n, logic e);
        for (int i = 0; i < n; i++) sb.push_back({4'b0000, e});
    endfunction

    function automatic void mark(int lo, int hi, int b);
        logic [4:0] t;
        for (int i = lo; i <= hi; i++) begin
            t = sb[i];
            t[b] = 1'b1;
            sb[i] = t;
        end
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({s, r, busy, collision, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=%b", {s, r, busy, collision, err}, 5'b0);
        end
        rst = 1'b1;
        fill(5, 1'b0);
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
        end
    endtask

    task automatic test_set();
        fill(32, 1'b0);
        mark(7, 8, SB);
        mark(7, 9, BB);
        set_in = 1'b1;
        for (int e = 0; e < 32; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL set e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
            if (e == 19) set_in = 1'b0;
        end
    endtask

    task automatic test_glitch();
        fill(16, 1'b0);
        clr_in = 1'b1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL glitch e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
            if (e == 2) clr_in = 1'b0;
        end
    endtask

    task automatic test_collision();
        fill(24, 1'b0);
        mark(7, 7, CB);
        mark(7, 8, RB);
        mark(7, 9, BB);
        set_in = 1'b1;
        clr_in = 1'b1;
        for (int e = 0; e < 24; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL collision e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
            if (e == 9) begin set_in = 1'b0; clr_in = 1'b0; end
        end
    endtask

    task automatic test_back_to_back();
        fill(30, 1'b0);
        mark(7, 8, SB);
        mark(7, 9, BB);
        mark(11, 12, RB);
        mark(11, 13, BB);
        set_in = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
            if (e == 0) clr_in = 1'b1;
            if (e == 15) begin set_in = 1'b0; clr_in = 1'b0; end
        end
    endtask

    task automatic test_err();
        fill(10, 1'b0);
        fill(40, 1'b1);
        mark(7, 8, SB);
        mark(7, 9, BB);
        mark(28, 29, RB);
        mark(28, 30, BB);
        tie0 = 1'b1;
        set_in = 1'b1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL err_sticky e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
            if (e == 10) set_in = 1'b0;
            if (e == 11) tie0 = 1'b0;
            if (e == 20) clr_in = 1'b1;
            if (e == 35) clr_in = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        fill(8, 1'b1);
        mark(7, 7, SB);
        mark(7, 7, BB);
        set_in = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL pre_reset e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
        end
        #1;
        rst = 1'b0;
        set_in = 1'b0;
        #1;
        n_chk++;
        if ({s, r, busy, collision, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b", {s, r, busy, collision, err}, 5'b0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        fill(14, 1'b0);
        for (int e = 0; e < 14; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_quiet e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
        end
        fill(20, 1'b0);
        mark(7, 8, SB);
        mark(7, 9, BB);
        set_in = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_chk++;
            if ({s, r, busy, collision, err} !== exp_v) begin
                n_fail++;
                $display("FAIL fresh_set e=%0d got=%b exp=%b", e, {s, r, busy, collision, err}, exp_v);
            end
            if (e == 10) set_in = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_glitch();
        test_collision();
        test_back_to_back();
        test_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
